// File: rtl/fft_mag_sq_stream.sv
// Turns framed complex FFT bins into scaled, saturated |X|^2 for the first N bins of each frame.
// Also tracks frame position, flags framing violations and counts completed frames.
module fft_mag_sq_stream #(
    parameter int IN_W  = 16,
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int FFT_N = 16,
    parameter int SHIFT = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = (FFT_N > 1) ? $clog2(FFT_N) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_valid,
    input  logic                   fft_sop,
    input  logic                   fft_eop,
    input  logic signed [IN_W-1:0] fft_real,
    input  logic signed [IN_W-1:0] fft_imag,
    output logic                   mag_valid,
    output logic [W-1:0]           mag_sq,
    output logic                   mag_last,
    output logic [IDX_W-1:0]       bin_idx,
    output logic                   frame_err,
    output logic [15:0]            frames_out
);

    localparam int SUM_W = 2 * IN_W;
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'((64'd1 << W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FFT_N - 1);
    localparam logic [CNT_W-1:0] LAST_FWD = CNT_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    // The most negative input squares to 2^(2*IN_W-2), which still fits as a positive value.
    function automatic logic [SUM_W-1:0] square(input logic signed [IN_W-1:0] x);
        logic signed [SUM_W-1:0] xe;
        logic signed [SUM_W-1:0] p;
        xe = SUM_W'(x);
        p  = xe * xe;
        return p;
    endfunction

    function automatic logic [W-1:0] shift_sat(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] sh;
        sh = sum >> SHIFT;
        if (sh > SAT_MAX)
            return '1;
        return sh[W-1:0];
    endfunction

    logic                   vld_p0, sop_p0, eop_p0;
    logic signed [IN_W-1:0] re_p0, im_p0;
    logic                   vld_p1, last_p1;
    logic [IDX_W-1:0]       idx_p1;
    logic [SUM_W-1:0]       re_sq_p1, im_sq_p1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, pos;
    logic             in_frame, leave, fwd, err;
    logic [IDX_W-1:0] idx;

    // Stage 0: register the raw input sample
    always_ff @(posedge clk) begin
        if (reset)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= fft_valid;
        sop_p0 <= fft_sop;
        eop_p0 <= fft_eop;
        re_p0  <= fft_real;
        im_p0  <= fft_imag;
    end

    // A sop sample is always bin 0; a frame closes on eop or on its last legal bin.
    assign pos      = sop_p0 ? '0 : cnt;
    assign in_frame = sop_p0 || (state != IDLE);
    assign leave    = eop_p0 || (pos == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (vld_p0 && in_frame) begin
            if (leave) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = (pos < LAST_FWD) ? PASS : DROP;
                cnt_nxt   = pos + CNT_W'(1);
            end
        end
    end

    always_comb begin
        fwd = 1'b0;
        err = 1'b0;
        idx = pos[IDX_W-1:0];
        if (vld_p0) begin
            if (!in_frame) begin
                err = 1'b1;
            end else begin
                fwd = sop_p0 || (state == PASS);
                err = (sop_p0 && state != IDLE) || (eop_p0 != (pos == LAST_CNT));
            end
        end
    end

    // Stage 1: squares, forwarding decision and framing error
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vld_p1    <= fwd;
            last_p1   <= fwd && (idx == LAST_IDX);
            frame_err <= err;
        end
        idx_p1   <= idx;
        re_sq_p1 <= square(re_p0);
        im_sq_p1 <= square(im_p0);
    end

    // Stage 2: sum, shift and saturate onto the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_valid  <= 1'b0;
            mag_last   <= 1'b0;
            mag_sq     <= '0;
            bin_idx    <= '0;
            frames_out <= '0;
        end else begin
            mag_valid <= vld_p1;
            mag_last  <= vld_p1 && last_p1;
            if (vld_p1) begin
                mag_sq  <= shift_sat(re_sq_p1 + im_sq_p1);
                bin_idx <= idx_p1;
            end
            if (vld_p1 && last_p1)
                frames_out <= frames_out + 16'd1;
        end
    end

endmodule
